// File: rtl/cic_decimator.sv
// ----------------------------------------------------------------------------
// cic_decimator
//   Anti-alias CIC decimation filter. N pipelined integrators run at the input
//   sample rate, every R-th accepted sample is handed to N combs (M = 1) that
//   evaluate in a single cycle, and the comb result is scaled down to OUT_W
//   bits. All arithmetic is ACC_W-bit two's complement with modulo wrap.
//
// Ports
//   CLOCK_50   in   1      system clock, all logic on posedge
//   reset      in   1      asynchronous, active-high reset
//   in_valid   in   1      data_in accepted on a posedge with in_valid = 1
//   data_in    in   IN_W   signed input sample
//   out_valid  out  1      one-cycle strobe, data_out holds a new sample
//   data_out   out  OUT_W  signed decimated output, held between strobes
//
// Configuration
//   CIC_ROUND_EN  defined: round half up before the slice, with positive
//                 saturation. Undefined: plain truncation by slicing.
// ----------------------------------------------------------------------------
module cic_decimator #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 16,
   parameter int R     = 6,
   parameter int N     = 3,
   parameter int ACC_W = 25
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [IN_W-1:0]  data_in,
   output logic             out_valid,
   output logic [OUT_W-1:0] data_out
);

   localparam int CNT_W = (R > 2) ? $clog2(R) : 1;

   logic [ACC_W-1:0] integ_q    [N];
   logic [ACC_W-1:0] integ_d    [N];
   logic [ACC_W-1:0] comb_dly_q [N];
   logic [ACC_W-1:0] comb_dly_d [N];
   logic [ACC_W-1:0] comb_c     [N+1];
   logic [CNT_W-1:0] dec_cnt_q, dec_cnt_d;
   logic [ACC_W-1:0] dec_sample_q, dec_sample_d;
   logic             dec_stb_q, dec_stb_d;
   logic [OUT_W-1:0] data_out_q, data_out_d;
   logic             out_valid_q, out_valid_d;
   logic [OUT_W-1:0] scaled;

   // Integrators, decimation counter and single-cycle comb chain.
   always_comb begin
      integ_d      = integ_q;
      comb_dly_d   = comb_dly_q;
      dec_cnt_d    = dec_cnt_q;
      dec_sample_d = dec_sample_q;
      dec_stb_d    = 1'b0;
      data_out_d   = data_out_q;
      out_valid_d  = 1'b0;

      if (in_valid) begin
         integ_d[0] = integ_q[0] + {{(ACC_W-IN_W){data_in[IN_W-1]}}, data_in};
         // Each later stage adds the registered (old) value of its predecessor.
         for (int unsigned k = 1; k < N; k++) begin
            integ_d[k] = integ_q[k] + integ_q[k-1];
         end
         if (dec_cnt_q == CNT_W'(R-1)) begin
            dec_cnt_d    = '0;
            dec_sample_d = integ_q[N-1];
            dec_stb_d    = 1'b1;
         end else begin
            dec_cnt_d = dec_cnt_q + 1'b1;
         end
      end

      comb_c[0] = dec_sample_q;
      for (int unsigned k = 0; k < N; k++) begin
         comb_c[k+1] = comb_c[k] - comb_dly_q[k];
         if (dec_stb_q) begin
            comb_dly_d[k] = comb_c[k];
         end
      end

      if (dec_stb_q) begin
         data_out_d  = scaled;
         out_valid_d = 1'b1;
      end
   end

`ifdef CIC_ROUND_EN
   logic [ACC_W:0] rnd_sum;
   logic           unused_rnd_lsbs;

   // One extra bit so that rounding the largest positive value is detectable.
   always_comb begin
      rnd_sum = {comb_c[N][ACC_W-1], comb_c[N]} + (ACC_W+1)'(2**(ACC_W-OUT_W-1));
      if (rnd_sum[ACC_W:ACC_W-1] == 2'b01) begin
         scaled = {1'b0, {(OUT_W-1){1'b1}}};
      end else begin
         scaled = rnd_sum[ACC_W-1 -: OUT_W];
      end
   end
   assign unused_rnd_lsbs = ^rnd_sum[ACC_W-OUT_W-1:0];
`else
   logic unused_trunc_lsbs;

   assign scaled            = comb_c[N][ACC_W-1 -: OUT_W];
   assign unused_trunc_lsbs = ^comb_c[N][ACC_W-OUT_W-1:0];
`endif

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         for (int unsigned k = 0; k < N; k++) begin
            integ_q[k]    <= '0;
            comb_dly_q[k] <= '0;
         end
         dec_cnt_q    <= '0;
         dec_sample_q <= '0;
         dec_stb_q    <= 1'b0;
         data_out_q   <= '0;
         out_valid_q  <= 1'b0;
      end else begin
         integ_q      <= integ_d;
         comb_dly_q   <= comb_dly_d;
         dec_cnt_q    <= dec_cnt_d;
         dec_sample_q <= dec_sample_d;
         dec_stb_q    <= dec_stb_d;
         data_out_q   <= data_out_d;
         out_valid_q  <= out_valid_d;
      end
   end

   assign data_out  = data_out_q;
   assign out_valid = out_valid_q;

endmodule
